// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// FSM states, opcode/funct values, ALU/NPC/EXT select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_J,
        CL_ADDI,
        CL_ORI,
        CL_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;

    function automatic logic [1:0] funct_to_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: OpCode/funct -> class and legal bit.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] OpCode,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output logic       legal
);

    always_comb begin
        cls = CL_ILL;
        case (OpCode)
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB ||
                    funct == FN_AND || funct == FN_OR)
                    cls = CL_R;
            end
            OP_LW:   cls = CL_LW;
            OP_SW:   cls = CL_SW;
            OP_BEQ:  cls = CL_BEQ;
            OP_J:    cls = CL_J;
            OP_ADDI: cls = CL_ADDI;
            OP_ORI:  cls = CL_ORI;
            default: cls = CL_ILL;
        endcase
        legal = (cls != CL_ILL);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with retire counter.
// Define MC_MEMWAIT_EN to add dm_ready, which stretches MEM until the data memory is ready.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MC_MEMWAIT_EN
    input  logic             dm_ready,
`endif
    input  logic [5:0]       OpCode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegW,
    output logic             MemR,
    output logic             MemW,
    output logic             RegDst,
    output logic             Mem2R,
    output logic             Alusrc,
    output logic [1:0]       ExtOp,
    output logic [1:0]       Aluctrl,
    output logic [1:0]       NPCOp,
    output logic [2:0]       state_o,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    state_t  state;
    iclass_t cls;
    logic    legal;
    logic    mem_go;
    logic    retire_now;
    logic    sel_src;
    logic [1:0] sel_ext;
    logic [1:0] sel_alu;

    mc_decode u_decode (
        .OpCode (OpCode),
        .funct  (funct),
        .cls    (cls),
        .legal  (legal)
    );

`ifdef MC_MEMWAIT_EN
    assign mem_go = dm_ready;
`else
    assign mem_go = 1'b1;
`endif

    assign state_o = state;

    assign retire_now = (state == ST_EXEC && (cls == CL_BEQ || cls == CL_J)) ||
                        (state == ST_MEM && mem_go && cls == CL_SW) ||
                        (state == ST_WB);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_FETCH;
            illegal    <= 1'b0;
            retire     <= 1'b0;
            retire_cnt <= '0;
        end else begin
            retire <= retire_now;
            if (retire_now)
                retire_cnt <= retire_cnt + CNT_W'(1);
            case (state)
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    if (legal) begin
                        state <= ST_EXEC;
                    end else begin
                        state   <= ST_HALT;
                        illegal <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (cls)
                        CL_R, CL_ADDI, CL_ORI: state <= ST_WB;
                        CL_LW, CL_SW:          state <= ST_MEM;
                        CL_BEQ, CL_J:          state <= ST_FETCH;
                        default: begin
                            state   <= ST_HALT;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_go)
                        state <= (cls == CL_LW) ? ST_WB : ST_FETCH;
                end
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_HALT;
            endcase
        end
    end

    // ALU-side selects per class; applied in EXEC and held through MEM(lw)/WB.
    always_comb begin
        sel_src = 1'b0;
        sel_ext = EXT_ZERO;
        sel_alu = ALU_ADD;
        case (cls)
            CL_R:               sel_alu = funct_to_alu(funct);
            CL_LW, CL_SW, CL_ADDI: begin
                sel_src = 1'b1;
                sel_ext = EXT_SIGN;
                sel_alu = ALU_ADD;
            end
            CL_ORI: begin
                sel_src = 1'b1;
                sel_ext = EXT_ZERO;
                sel_alu = ALU_OR;
            end
            CL_BEQ:             sel_alu = ALU_SUB;
            default: ;
        endcase
    end

    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RegW    = 1'b0;
        MemR    = 1'b0;
        MemW    = 1'b0;
        RegDst  = 1'b0;
        Mem2R   = 1'b0;
        Alusrc  = 1'b0;
        ExtOp   = EXT_ZERO;
        Aluctrl = ALU_ADD;
        NPCOp   = NPC_PC4;
        case (state)
            ST_FETCH: begin
                IRWr  = 1'b1;
                PCWr  = 1'b1;
                NPCOp = NPC_PC4;
            end
            ST_EXEC: begin
                Alusrc  = sel_src;
                ExtOp   = sel_ext;
                Aluctrl = sel_alu;
                if (cls == CL_BEQ) begin
                    NPCOp = NPC_BR;
                    PCWr  = zero;
                end else if (cls == CL_J) begin
                    NPCOp = NPC_JMP;
                    PCWr  = 1'b1;
                end
            end
            ST_MEM: begin
                if (cls == CL_LW) begin
                    MemR    = 1'b1;
                    Alusrc  = sel_src;
                    ExtOp   = sel_ext;
                    Aluctrl = sel_alu;
                end else if (cls == CL_SW) begin
                    MemW = 1'b1;
                end
            end
            ST_WB: begin
                RegW    = 1'b1;
                RegDst  = (cls != CL_R);
                Mem2R   = (cls == CL_LW);
                Alusrc  = sel_src;
                ExtOp   = sel_ext;
                Aluctrl = sel_alu;
            end
            default: ;
        endcase
        // Reset abandons the instruction immediately, even mid-cycle.
        if (!rst) begin
            PCWr = 1'b0;
            IRWr = 1'b0;
            RegW = 1'b0;
            MemR = 1'b0;
            MemW = 1'b0;
        end
    end

endmodule
